// File: rtl/decode_sequencer.sv
// Multi-cycle decode/execute sequencer in front of a 16x16 register file: IDLE -> READ -> EXEC -> WB.
// Optional status flags are built only when the STATUS_FLAGS_EN macro is defined.
module decode_sequencer #(
  parameter int ZERO_REG_PROTECT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instr_in,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [3:0]  Reg1,
  output logic [3:0]  Reg2,
  input  logic [15:0] ReadData1,
  input  logic [15:0] ReadData2,
  output logic [15:0] WriteData,
  output logic        regwrite,
  output logic        busy,
  output logic        illegal_op,
  output logic [3:0]  flags
);

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t              state;
  logic [3:0]          op_p0;
  logic [3:0]          sh_p0;
  logic [DATA_W-1:0]   a_p1;
  logic [DATA_W-1:0]   b_p1;
  logic [DATA_W-1:0]   result_p2;
  logic                accept;

  function automatic logic [DATA_W-1:0] alu_f(
    input logic [3:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [3:0]        sh
  );
    logic [DATA_W-1:0] r;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = a << sh;
      4'd6:    r = a >> sh;
      4'd7:    r = b;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign accept      = instr_ready && instr_valid;
  assign result_p2   = alu_f(op_p0, a_p1, b_p1, sh_p0);

  // Stage 0: instruction latched at accept; stage 1: operands captured at end of READ
  always_ff @(posedge clock) begin
    if (accept) begin
      op_p0 <= instr_in[15:12];
      sh_p0 <= instr_in[3:0];
    end
    if (state == READ) begin
      a_p1 <= ReadData1;
      b_p1 <= ReadData2;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      Reg1       <= '0;
      Reg2       <= '0;
      WriteData  <= '0;
      regwrite   <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            Reg1  <= instr_in[11:8];
            Reg2  <= instr_in[7:4];
            state <= READ;
          end
        end
        READ: state <= EXEC;
        EXEC: begin
          // Opcodes 8..F carry op[3]=1: flag and drop without a writeback cycle
          if (op_p0[3]) begin
            illegal_op <= 1'b1;
            state      <= IDLE;
          end else begin
            WriteData <= result_p2;
            regwrite  <= !((ZERO_REG_PROTECT != 0) && (Reg1 == 4'd0));
            state     <= WB;
          end
        end
        WB: begin
          regwrite <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STATUS_FLAGS_EN
  function automatic logic [3:0] flags_f(
    input logic [3:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [DATA_W-1:0] r
  );
    logic [DATA_W:0] sum;
    logic            c;
    logic            v;
    sum = {1'b0, a} + {1'b0, b};
    c   = 1'b0;
    v   = 1'b0;
    if (op == 4'd0) begin
      c = sum[DATA_W];
      v = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
    end else if (op == 4'd1) begin
      c = (a >= b);
      v = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
    end
    return {(r == '0), r[DATA_W-1], c, v};
  endfunction

  // Stage 2: flags follow the result of legal ops only
  always_ff @(posedge clock) begin
    if (!reset)
      flags <= 4'b0000;
    else if (state == EXEC && !op_p0[3])
      flags <= flags_f(op_p0, a_p1, b_p1, result_p2);
  end
`else
  assign flags = 4'b0000;
`endif

endmodule
